// File: rtl/uart_pixel_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pixel_loader_pkg                                                      |
// | Shared image geometry defaults, loader state encodings, slot helper.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pixel_loader_pkg;

    localparam int c_DEF_CHANNELS = 3;
    localparam int c_DEF_IMG_W    = 160;
    localparam int c_DEF_IMG_H    = 120;
    localparam int c_DEF_ADDR_W   = 15;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_S_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_S_COLLECT = 2'd1;
    localparam logic [c_STATE_W-1:0] c_S_WRITE   = 2'd2;

    // LSB position of byte slot 'slot' inside a packed pixel word.
    function automatic int slot_lsb(input int slot, input int channels, input bit msb_first);
        return msb_first ? (channels - 1 - slot) * 8 : slot * 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_pixel_loader_pulse_stretch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pixel_loader_pulse_stretch                                            |
// | Holds its output high for HOLD_CLKS clocks after the most recent pulse.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_pixel_loader_pulse_stretch #(
    parameter int HOLD_CLKS = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    output logic o_stretched
);
    localparam int c_CW = $clog2(HOLD_CLKS + 1);
    localparam logic [c_CW-1:0] c_HOLD = c_CW'(HOLD_CLKS);

    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_pulse) begin
            w_count_next = c_HOLD;
        end else if (r_count != '0) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_stretched = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/uart_pixel_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pixel_loader                                                          |
// | Packs UART bytes into pixels and writes them to frame RAM sequentially.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_pixel_loader
    import uart_pixel_loader_pkg::*;
#(
    parameter int CHANNELS      = c_DEF_CHANNELS,
    parameter int IMG_W         = c_DEF_IMG_W,
    parameter int IMG_H         = c_DEF_IMG_H,
    parameter int ADDR_W        = c_DEF_ADDR_W,
    parameter int TIMEOUT_CLKS  = 52080,
    parameter int LED_HOLD_CLKS = 2500000,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Enable,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Wr_En,
    output logic [ADDR_W-1:0]     o_Wr_Addr,
    output logic [CHANNELS*8-1:0] o_Wr_Data,
    output logic                  o_Frame_Done,
    output logic                  o_Sync_Err,
    output logic                  o_Busy,
    output logic                  o_Led
);
    localparam int c_CHW = $clog2(CHANNELS + 1);
    localparam int c_TMW = $clog2(TIMEOUT_CLKS + 1);
    localparam int c_DW  = CHANNELS * 8;
    localparam logic [c_CHW-1:0]  c_LAST_CHAN = c_CHW'(CHANNELS - 1);
    localparam logic [c_TMW-1:0]  c_TO_LAST   = c_TMW'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_PIX  = ADDR_W'(IMG_W * IMG_H - 1);

    logic [c_STATE_W-1:0] r_state,      w_state_next;
    logic [c_CHW-1:0]     r_chan_cnt,   w_chan_next;
    logic [ADDR_W-1:0]    r_pix_cnt,    w_pix_next;
    logic [c_DW-1:0]      r_pack,       w_pack_next;
    logic [c_TMW-1:0]     r_timer,      w_timer_next;
    logic                 r_wr_en,      w_wr_en_next;
    logic [ADDR_W-1:0]    r_wr_addr,    w_addr_next;
    logic [c_DW-1:0]      r_wr_data,    w_data_next;
    logic                 r_frame_done, w_done_next;
    logic                 r_sync_err,   w_err_next;
    logic                 w_accept;

    always_comb begin
        w_accept     = i_Rx_DV & i_Enable;
        w_state_next = r_state;
        w_chan_next  = r_chan_cnt;
        w_pix_next   = r_pix_cnt;
        w_pack_next  = r_pack;
        w_timer_next = '0;
        w_wr_en_next = 1'b0;
        w_addr_next  = r_wr_addr;
        w_data_next  = r_wr_data;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;

        for (int k = 0; k < CHANNELS; k++) begin
            if (w_accept && (r_chan_cnt == c_CHW'(k))) begin
                w_pack_next[slot_lsb(k, CHANNELS, MSB_FIRST) +: 8] = i_Rx_Byte;
            end
        end

        // A byte is taken in any state, so a strobe during the WRITE cycle lands in slot 0.
        if (w_accept) begin
            if (r_chan_cnt == c_LAST_CHAN) begin
                w_state_next = c_S_WRITE;
                w_chan_next  = '0;
                w_wr_en_next = 1'b1;
                w_addr_next  = r_pix_cnt;
                w_data_next  = w_pack_next;
                w_done_next  = (r_pix_cnt == c_LAST_PIX);
                w_pix_next   = w_done_next ? '0 : r_pix_cnt + ADDR_W'(1);
            end else begin
                w_state_next = c_S_COLLECT;
                w_chan_next  = r_chan_cnt + c_CHW'(1);
            end
        end else if (r_state == c_S_COLLECT) begin
            if (r_timer == c_TO_LAST) begin
                w_state_next = c_S_IDLE;
                w_chan_next  = '0;
                w_err_next   = 1'b1;
            end else begin
                w_timer_next = r_timer + c_TMW'(1);
            end
        end else begin
            w_state_next = c_S_IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state      <= c_S_IDLE;
            r_chan_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_pack       <= '0;
            r_timer      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_chan_cnt   <= w_chan_next;
            r_pix_cnt    <= w_pix_next;
            r_pack       <= w_pack_next;
            r_timer      <= w_timer_next;
            r_wr_en      <= w_wr_en_next;
            r_wr_addr    <= w_addr_next;
            r_wr_data    <= w_data_next;
            r_frame_done <= w_done_next;
            r_sync_err   <= w_err_next;
        end
    end

    // LED tracks raw strobes, independent of i_Enable.
    uart_pixel_loader_pulse_stretch #(
        .HOLD_CLKS (LED_HOLD_CLKS)
    ) u_led_stretch (
        .i_clk       (i_Clock),
        .i_rst_n     (i_Reset),
        .i_pulse     (i_Rx_DV),
        .o_stretched (o_Led)
    );

    assign o_Wr_En      = r_wr_en;
    assign o_Wr_Addr    = r_wr_addr;
    assign o_Wr_Data    = r_wr_data;
    assign o_Frame_Done = r_frame_done;
    assign o_Sync_Err   = r_sync_err;
    assign o_Busy       = (r_pix_cnt != '0) || (r_chan_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_pixel_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_pixel_loader                                                       |
// | Directed and randomized bench against a byte-queue pixel model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_pixel_loader;

    localparam int CH = 3;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int TO = 100;
    localparam int LH = 20;

    logic          clk = 1'b0;
    logic          i_Reset;
    logic          i_Enable;
    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          o_Wr_En;
    logic [AW-1:0] o_Wr_Addr;
    logic [23:0]   o_Wr_Data;
    logic          o_Frame_Done;
    logic          o_Sync_Err;
    logic          o_Busy;
    logic          o_Led;

    logic          dv1;
    logic [7:0]    byte1;
    logic          wr_en1;
    logic [AW-1:0] addr1;
    logic [7:0]    data1;
    logic          done1;
    logic          err1;
    logic          busy1;
    logic          led1;

    always #5 clk = ~clk;

    uart_pixel_loader #(
        .CHANNELS(CH), .IMG_W(W), .IMG_H(H), .ADDR_W(AW),
        .TIMEOUT_CLKS(TO), .LED_HOLD_CLKS(LH), .MSB_FIRST(1'b1)
    ) dut (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
        .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
        .o_Frame_Done(o_Frame_Done), .o_Sync_Err(o_Sync_Err),
        .o_Busy(o_Busy), .o_Led(o_Led)
    );

    uart_pixel_loader #(
        .CHANNELS(1), .IMG_W(W), .IMG_H(H), .ADDR_W(AW),
        .TIMEOUT_CLKS(TO), .LED_HOLD_CLKS(LH), .MSB_FIRST(1'b1)
    ) dut1 (
        .i_Clock(clk), .i_Reset(i_Reset), .i_Enable(1'b1),
        .i_Rx_DV(dv1), .i_Rx_Byte(byte1),
        .o_Wr_En(wr_en1), .o_Wr_Addr(addr1), .o_Wr_Data(data1),
        .o_Frame_Done(done1), .o_Sync_Err(err1),
        .o_Busy(busy1), .o_Led(led1)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: bytes of the pending pixel, next pixel index, event times.
    logic [7:0] pend[$];
    int         pix      = 0;
    int         edge_n   = 0;
    int         last_acc = 0;
    int         last_dv  = 0;
    bit         have_dv  = 0;
    logic        exp_wr_en, exp_done, exp_err, exp_busy, exp_led;
    logic [31:0] exp_addr, exp_data;

    int wr_seen, err_seen, done_seen;
    logic [31:0] done_addr_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        pix = 0; have_dv = 0;
        exp_wr_en = 0; exp_done = 0; exp_err = 0; exp_busy = 0; exp_led = 0;
        exp_addr = 0; exp_data = 0;
    endtask

    task automatic model_edge(input logic dv, input logic en, input logic [7:0] b);
        logic [31:0] word;
        exp_wr_en = 0; exp_done = 0; exp_err = 0;
        if (dv && en) begin
            pend.push_back(b);
            last_acc = edge_n;
            if (pend.size() == CH) begin
                word = 0;
                foreach (pend[i]) word = (word << 8) | 32'(pend[i]);
                exp_wr_en = 1;
                exp_addr  = pix;
                exp_data  = word;
                exp_done  = (pix == W * H - 1);
                pix       = (pix + 1) % (W * H);
                pend.delete();
            end
        end else if (pend.size() != 0 && (edge_n - last_acc) == TO) begin
            exp_err = 1;
            pend.delete();
        end
        if (dv) begin
            have_dv = 1;
            last_dv = edge_n;
        end
        exp_led  = have_dv && ((edge_n - last_dv) < LH);
        exp_busy = (pix != 0) || (pend.size() != 0);
    endtask

    task automatic step(input logic dv, input logic en, input logic [7:0] b);
        i_Rx_DV = dv; i_Enable = en; i_Rx_Byte = b;
        @(posedge clk);
        edge_n++;
        model_edge(dv, en, b);
        #1;
        chk("wr_en",    o_Wr_En,      exp_wr_en);
        chk("wr_addr",  o_Wr_Addr,    exp_addr);
        chk("wr_data",  o_Wr_Data,    exp_data);
        chk("frm_done", o_Frame_Done, exp_done);
        chk("sync_err", o_Sync_Err,   exp_err);
        chk("busy",     o_Busy,       exp_busy);
        chk("led",      o_Led,        exp_led);
        if (o_Wr_En)    wr_seen++;
        if (o_Sync_Err) err_seen++;
        if (o_Frame_Done) begin
            done_seen++;
            done_addr_obs = 32'(o_Wr_Addr);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, 1'b1, b);
        repeat (gap - 1) step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic do_reset();
        i_Rx_DV = 0; i_Enable = 1; i_Rx_Byte = 0;
        #2 i_Reset = 0;
        #1;
        chk("rst_wr_en", o_Wr_En, 0);
        chk("rst_addr",  o_Wr_Addr, 0);
        chk("rst_data",  o_Wr_Data, 0);
        chk("rst_done",  o_Frame_Done, 0);
        chk("rst_err",   o_Sync_Err, 0);
        chk("rst_busy",  o_Busy, 0);
        chk("rst_led",   o_Led, 0);
        model_reset();
        wr_seen = 0; err_seen = 0; done_seen = 0; done_addr_obs = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 i_Reset = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 0; i_Enable = 1; i_Rx_DV = 0; i_Rx_Byte = 0;
        dv1 = 0; byte1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 i_Reset = 1;

        // Single-channel build: each byte is a pixel, written one clock later.
        dv1 = 1; byte1 = 8'h7F;
        @(posedge clk); #1;
        dv1 = 0;
        chk("c1_wr_en", wr_en1, 1);
        chk("c1_addr",  addr1, 0);
        chk("c1_data",  data1, 8'h7F);
        chk("c1_busy",  busy1, 1);
        @(posedge clk); #1;
        chk("c1_wr_off", wr_en1, 0);

        // Basic pixel with 10-clock byte spacing.
        do_reset();
        send(8'h11, 10);
        send(8'h22, 10);
        step(1'b1, 1'b1, 8'h33);
        chk("t1_wr_en", o_Wr_En, 1);
        chk("t1_addr",  o_Wr_Addr, 0);
        chk("t1_data",  o_Wr_Data, 24'h112233);
        repeat (5) step(1'b0, 1'b1, 8'h00);

        // Full frame, done pulse on last address, then wrap to 0.
        do_reset();
        for (int i = 0; i < W * H * CH; i++) send(8'($urandom), 2);
        chk("t2_writes",    wr_seen, W * H);
        chk("t2_done_cnt",  done_seen, 1);
        chk("t2_done_addr", done_addr_obs, W * H - 1);
        for (int i = 0; i < CH; i++) send(8'($urandom), 2);
        chk("t2_wrap_addr", o_Wr_Addr, 0);

        // Timeout discards the partial pixel.
        do_reset();
        send(8'hAA, 1);
        send(8'hBB, 1);
        repeat (150) step(1'b0, 1'b1, 8'h00);
        chk("t3_err_cnt",  err_seen, 1);
        chk("t3_no_write", wr_seen, 0);
        send(8'h01, 1);
        send(8'h02, 1);
        step(1'b1, 1'b1, 8'h03);
        chk("t3_addr", o_Wr_Addr, 0);
        chk("t3_data", o_Wr_Data, 24'h010203);

        // Disabled: strobes only light the LED.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        repeat (25) step(1'b0, 1'b0, 8'h00);
        chk("t4_no_write", wr_seen, 0);
        chk("t4_led_off",  o_Led, 0);

        // Reset two bytes into pixel 5.
        do_reset();
        for (int i = 0; i < 5 * CH + 2; i++) send(8'($urandom), 2);
        chk("t5_busy_pre", o_Busy, 1);
        do_reset();
        for (int i = 0; i < CH; i++) send(8'($urandom), 2);
        chk("t5_addr", o_Wr_Addr, 0);

        // Randomized traffic including near-timeout gaps and stray resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 4) begin
                repeat ($urandom_range(90, 110)) step(1'b0, 1'($urandom_range(0, 1)), 8'h00);
            end else if (r == 199) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) != 0), 8'($urandom));
            end
        end
        step(1'b0, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
